// File: rtl/uart_rx_fifo.sv
// UART receive path: 2-flop synchronizer, 16x oversampled 8N1 receiver and a
// first-word-fall-through byte FIFO with frame-error and overrun pulses.
module uart_rx_fifo #(
  parameter int unsigned BAUDRATE_COUNT = 5,
  parameter int unsigned FIFO_SIZE      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TICK_W = (BAUDRATE_COUNT > 1) ? $clog2(BAUDRATE_COUNT) : 1;
  localparam int unsigned ADDR_W = $clog2(FIFO_SIZE);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUDRATE_COUNT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_SIZE);
  localparam logic [3:0]        SAMP_MID  = 4'd7;
  localparam logic [3:0]        SAMP_LAST = 4'd15;
  localparam logic [2:0]        BIT_LAST  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Line synchronizer, reset to the idle level
  logic sync1;
  logic rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Oversample tick generator
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Receiver FSM state
  state_t     state;
  state_t     state_nxt;
  logic [3:0] samp_cnt;
  logic [3:0] samp_nxt;
  logic [2:0] bit_cnt;
  logic [2:0] bit_nxt;
  logic [7:0] shift_reg;
  logic [7:0] shift_nxt;
  logic       push_c;
  logic       pop_c;
  logic       frame_err_nxt;
  logic       overrun_nxt;

  // FIFO state
  logic [7:0]        mem [FIFO_SIZE];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_nxt;
  logic [ADDR_W-1:0] wr_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [7:0]        head_nxt;
  logic              fifo_full;

  assign fifo_full = (count == CNT_FULL);
  assign pop_c     = rx && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      samp_cnt  <= samp_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    samp_nxt      = samp_cnt;
    bit_nxt       = bit_cnt;
    shift_nxt     = shift_reg;
    push_c        = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            samp_nxt  = '0;
          end
        end
        START: begin
          // Re-check the line in the middle of the start bit to reject glitches
          if (samp_cnt == SAMP_MID) begin
            samp_nxt = '0;
            if (!rxs) begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            samp_nxt = samp_cnt + 4'd1;
          end
        end
        DATA: begin
          if (samp_cnt == SAMP_LAST) begin
            samp_nxt  = '0;
            shift_nxt = {rxs, shift_reg[7:1]};
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + 3'd1;
            end
          end else begin
            samp_nxt = samp_cnt + 4'd1;
          end
        end
        STOP: begin
          if (samp_cnt == SAMP_LAST) begin
            samp_nxt  = '0;
            state_nxt = IDLE;
            if (!rxs) begin
              frame_err_nxt = 1'b1;
            end else if (!fifo_full || pop_c) begin
              push_c = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
            end
          end else begin
            samp_nxt = samp_cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FIFO next state; the head is precomputed so rx_data can be registered
  always_comb begin
    rd_nxt    = pop_c  ? rd_ptr + ADDR_W'(1) : rd_ptr;
    wr_nxt    = push_c ? wr_ptr + ADDR_W'(1) : wr_ptr;
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_nxt = count - CNT_W'(1);
    end
    head_nxt = mem[rd_nxt];
    // The new byte becomes the head when it lands in the slot being exposed
    if (push_c && (wr_ptr == rd_nxt)) begin
      head_nxt = shift_reg;
    end
    if (count_nxt == '0) begin
      head_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      rx_full   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      count     <= count_nxt;
      rx_data   <= head_nxt;
      rx_ready  <= (count_nxt != '0);
      rx_full   <= (count_nxt == CNT_FULL);
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed 8N1 frames, scoreboard of expected bytes
// checked by a monitor on every pop, plus flag pulse counting.
module tb_uart_rx_fifo;

  localparam int unsigned BAUDRATE_COUNT = 5;
  localparam int unsigned FIFO_SIZE      = 4;
  localparam int          BIT_CLKS       = 16 * BAUDRATE_COUNT;
  localparam int          STOP_EDGE      = 763;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(
    .BAUDRATE_COUNT(BAUDRATE_COUNT),
    .FIFO_SIZE     (FIFO_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_full  (rx_full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; tick edges fall where cyc % 5 == 0
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       fe_prev = 1'b0;
  logic       ov_prev = 1'b0;
  logic       ready_prev = 1'b0;
  int         ready_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted pop against the scoreboard, count flag pulses
  always @(negedge clk) begin
    if (rst) begin
      fe_prev    = 1'b0;
      ov_prev    = 1'b0;
      ready_prev = 1'b0;
    end else begin
      if (rx && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got %0h expected none (t=%0t)", rx_data, $time);
        end else begin
          check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) begin
        fe_cnt++;
        check("frame_err_width", 32'(fe_prev), 32'(0));
      end
      if (overrun) begin
        ov_cnt++;
        check("overrun_width", 32'(ov_prev), 32'(0));
      end
      if (rx_ready && !ready_prev) ready_rise_cyc = cyc;
      fe_prev    = frame_err;
      ov_prev    = overrun;
      ready_prev = rx_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop();
    rx = 1'b1;
    step(1);
    rx = 1'b0;
    step(1);
  endtask

  // Sends one frame after an idle gap. Start edge is placed at cyc%5==2 so
  // that, after the 2-flop synchronizer, the first low sample lands on a tick.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit pop_at_stop, input int rst_at,
                            output int start_cyc);
    int idx;
    uart_rx = 1'b1;
    step(100);
    while ((cyc % 5) != 2) step(1);
    start_cyc = cyc;
    uart_rx   = 1'b0;
    for (int k = 1; k <= 10 * BIT_CLKS; k++) begin
      step(1);
      if (k == rst_at) begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        step(1);
        rst = 1'b0;
        return;
      end
      idx = k / BIT_CLKS;
      if (idx == 0)      uart_rx = 1'b0;
      else if (idx <= 8) uart_rx = b[idx-1];
      else if (idx == 9) uart_rx = stop_bit;
      else               uart_rx = 1'b1;
      rx = pop_at_stop && (k == STOP_EDGE - 1);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         s;
    logic [7:0] t2_bytes[4];
    t2_bytes = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    rst     = 1'b1;
    uart_rx = 1'b1;
    rx      = 1'b0;
    step(5);
    rst = 1'b0;
    check("rst_rx_data",   32'(rx_data),   32'(0));
    check("rst_rx_ready",  32'(rx_ready),  32'(0));
    check("rst_rx_full",   32'(rx_full),   32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    check("rst_overrun",   32'(overrun),   32'(0));

    // 1: single byte, latency and head value
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 0, s);
    check("t1_latency", 32'(ready_rise_cyc - s), 32'(STOP_EDGE));
    check("t1_ready", 32'(rx_ready), 32'(1));
    check("t1_head", 32'(rx_data), 32'hA5);
    check("t1_flags", 32'(fe_cnt + ov_cnt), 32'(0));
    pop();
    check("t1_empty", 32'(rx_ready), 32'(0));

    // 2: fill, overrun on fifth byte, drain in order
    foreach (t2_bytes[i]) begin
      exp_q.push_back(t2_bytes[i]);
      send_frame(t2_bytes[i], 1'b1, 1'b0, 0, s);
    end
    check("t2_full", 32'(rx_full), 32'(1));
    send_frame(8'h69, 1'b1, 1'b0, 0, s);
    check("t2_overrun_cnt", 32'(ov_cnt), 32'(1));
    check("t2_still_full", 32'(rx_full), 32'(1));
    repeat (4) pop();
    check("t2_drained_ready", 32'(rx_ready), 32'(0));
    check("t2_drained_data", 32'(rx_data), 32'(0));
    check("t2_drained_full", 32'(rx_full), 32'(0));

    // 3: short low glitch
    uart_rx = 1'b0;
    step(20);
    uart_rx = 1'b1;
    step(200);
    check("t3_ready", 32'(rx_ready), 32'(0));
    check("t3_fe_cnt", 32'(fe_cnt), 32'(0));
    check("t3_ov_cnt", 32'(ov_cnt), 32'(1));

    // 4: framing error, then a good frame
    send_frame(8'h96, 1'b0, 1'b0, 0, s);
    check("t4_fe_cnt", 32'(fe_cnt), 32'(1));
    check("t4_ready", 32'(rx_ready), 32'(0));
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1'b1, 1'b0, 0, s);
    check("t4_head", 32'(rx_data), 32'h69);
    pop();

    // 5: pop in the stop-sample cycle while full, then pop while empty
    foreach (t2_bytes[i]) begin
      exp_q.push_back(t2_bytes[i]);
      send_frame(t2_bytes[i], 1'b1, 1'b0, 0, s);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 0, s);
    check("t5_ov_cnt", 32'(ov_cnt), 32'(1));
    check("t5_full", 32'(rx_full), 32'(1));
    check("t5_head", 32'(rx_data), 32'h5A);
    repeat (4) pop();
    check("t5_empty", 32'(rx_ready), 32'(0));
    pop();
    check("t5_underflow_ready", 32'(rx_ready), 32'(0));
    check("t5_underflow_full", 32'(rx_full), 32'(0));
    check("t5_underflow_data", 32'(rx_data), 32'(0));
    check("t5_queue_empty", 32'(exp_q.size()), 32'(0));

    // 6: reset mid-frame with a byte already buffered
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 0, s);
    check("t6_pre_ready", 32'(rx_ready), 32'(1));
    exp_q.delete();
    send_frame(8'hC3, 1'b1, 1'b0, 5 * BIT_CLKS, s);
    check("t6_rst_ready", 32'(rx_ready), 32'(0));
    check("t6_rst_full", 32'(rx_full), 32'(0));
    check("t6_rst_data", 32'(rx_data), 32'(0));
    check("t6_rst_flags", 32'({frame_err, overrun}), 32'(0));
    step(1000);
    check("t6_no_partial", 32'(rx_ready), 32'(0));
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 0, s);
    check("t6_head", 32'(rx_data), 32'h3C);
    pop();
    check("t6_final_ready", 32'(rx_ready), 32'(0));
    check("t6_queue_empty", 32'(exp_q.size()), 32'(0));
    check("t6_fe_cnt", 32'(fe_cnt), 32'(1));
    check("t6_ov_cnt", 32'(ov_cnt), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive half of the team UART. It converts the asynchronous serial line into bytes and matches the framing of the existing transmitter: 1 start bit, 8 data bits sent LSB first, 1 stop bit, no parity, and an idle-high line. It uses a 16x oversampled receive state machine. Received bytes are buffered in a FIFO with first-word-fall-through so the host sees them without an extra read cycle. The rx/rx_ready/rx_data naming and the BAUDRATE_COUNT/FIFO_SIZE parameters match the uart top so that this block can replace its receive path directly.

Parameters:
BAUDRATE_COUNT, 5, number of clk cycles per oversample tick; one bit period is 16*BAUDRATE_COUNT clocks; minimum 1.
FIFO_SIZE, 4, FIFO depth in bytes; must be a power of two, 2 or more.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
uart_rx  input  1  asynchronous serial line, idle high.
rx  input  1  pop strobe; one cycle pops the FIFO head.
rx_data  output  8  FIFO head byte; valid while rx_ready=1.
rx_ready  output  1  FIFO not empty.
rx_full  output  1  FIFO holds FIFO_SIZE bytes.
frame_err  output  1  one-cycle pulse when a received byte has a bad stop bit.
overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - rx_data=0, rx_ready=0, rx_full=0, frame_err=0, overrun=0.
  - FIFO is emptied.
  - FSM is in IDLE; tick counter, sample counter and bit counter are 0.
  - Both synchronizer flops are set to 1.
- Reset applied mid-frame discards the partial byte; nothing is pushed.
- Synchronizer: uart_rx passes through 2 flops; all line decisions use the synchronized value rxs, which lags the pin by 2 clocks.
- Tick generator:
  - Counter runs 0..BAUDRATE_COUNT-1 and wraps.
  - tick=1 for one clock when the count is BAUDRATE_COUNT-1.
  - Free-running after reset.
- FSM (advances only on tick; s = sample count 0..15, n = bit count 0..7):
  - IDLE: if rxs=0 on a tick, go to START with s=0.
  - START: s increments each tick. When s=7 (mid start bit):
    - rxs=0: go to DATA with s=0, n=0.
    - rxs=1: glitch; return to IDLE, no flags.
  - DATA: on the tick where s=15, shift rxs into shift register bit 7 (right shift) and reset s=0.
    - If n=7, go to STOP; otherwise n increments.
    - After 8 shifts the first received bit sits in bit 0.
  - STOP: on the tick where s=15, sample rxs and return to IDLE.
    - rxs=1, FIFO not full (or pop in the same cycle): push the byte.
    - rxs=1, FIFO full and no pop: drop the byte; overrun=1 for one clock.
    - rxs=0: drop the byte; frame_err=1 for one clock; the FIFO is untouched.
    - After a framing error, IDLE requires rxs=0 on a tick to start again, so a stuck-low line re-enters START; this is accepted behaviour.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_SIZE) bits that wrap modulo FIFO_SIZE.
  - Occupancy count is 0..FIFO_SIZE.
  - Push latency: the byte is written on the clock edge of the STOP sample; rx_ready and rx_data are valid from the next cycle.
  - Pop (rx=1, rx_ready=1): the head advances on that edge and the next byte (if any) appears in rx_data the following cycle.
  - Pop while empty is ignored: no underflow and no pointer change.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This also applies when full: no overrun, and the new byte enters the freed slot.
  - rx_full = (count == FIFO_SIZE); rx_ready = (count != 0); both are registered-consistent with the count.
  - rx_data is 0 while the FIFO is empty.

Test Plan:
(Bench uses BAUDRATE_COUNT=5 and FIFO_SIZE=4, so one bit = 80 clocks.)
1. Drive frame 0xA5 (LSB first, stop=1), no pops -> rx_ready rises about 760 clocks after the start edge (9.5 bits plus synchronizer); rx_data=8'hA5; frame_err=0 and overrun=0 throughout.
2. Send 0xA5, 0x5A, 0x3C, 0xC3, then 0x69, no pops -> rx_full=1 after the 4th byte; overrun pulses once at the 0x69 stop bit; successive pops return A5, 5A, 3C, C3, then rx_ready=0.
3. Drive uart_rx low for 20 clocks, then high -> FSM returns to IDLE; no push, no flags; rx_ready stays 0.
4. Send 0x96 with the stop bit low -> frame_err is a single-cycle pulse; FIFO count unchanged; then a normal 0x69 frame is received correctly.
5. With the FIFO full, assert rx in exactly the stop-sample cycle of 0x5A -> no overrun; count stays 4; the last entry is 0x5A. Also assert rx while empty -> no change.
6. Assert rst for 1 clock midway through the DATA bits of 0xC3 -> all outputs return to reset values; that partial byte is never pushed; the next full 0x3C frame is received correctly.
